wb_regfile: RTL and testbench

- Consumer end of the execute-stage result interface: destination register address, write enable and 32-bit result data.
- Carries each result through two pipeline registers, EX/MEM then MEM/WB, and commits it into a 32x32 general-purpose register file.
- Provides two read ports to the decode stage. Each port forwards from in-flight results so that decode always sees the newest value.

---
 rtl/wb_regfile_if.sv | 25 ++
 rtl/wb_regfile.sv | 56 +++++
 tb/tb_wb_regfile.sv | 123 ++++++++++++
 3 files changed

// File: rtl/wb_regfile_if.sv
// wb_regfile_if: execute-result, stall/flush, read-port and commit signals of the writeback register file.
interface wb_regfile_if #(parameter int REG_W = 32, parameter int ADDR_W = 5);
  logic [ADDR_W-1:0] ex_wd_i;
  logic              ex_wreg_i;
  logic [REG_W-1:0]  ex_wdata_i;
  logic              stall_i;
  logic              flush_i;
  logic              re1_i;
  logic [ADDR_W-1:0] raddr1_i;
  logic [REG_W-1:0]  rdata1_o;
  logic              re2_i;
  logic [ADDR_W-1:0] raddr2_i;
  logic [REG_W-1:0]  rdata2_o;
  logic              wb_we_o;
  logic [ADDR_W-1:0] wb_waddr_o;
  logic [REG_W-1:0]  wb_wdata_o;
  modport slave (
    input  ex_wd_i, ex_wreg_i, ex_wdata_i, stall_i, flush_i, re1_i, raddr1_i, re2_i, raddr2_i,
    output rdata1_o, rdata2_o, wb_we_o, wb_waddr_o, wb_wdata_o
  );
  modport master (
    output ex_wd_i, ex_wreg_i, ex_wdata_i, stall_i, flush_i, re1_i, raddr1_i, re2_i, raddr2_i,
    input  rdata1_o, rdata2_o, wb_we_o, wb_waddr_o, wb_wdata_o
  );
endinterface

// File: rtl/wb_regfile.sv
// wb_regfile: two-stage result pipeline committing into a register file with forwarding read ports.
module wb_regfile #(
  parameter int REG_NUM = 32,
  parameter int REG_W   = 32,
  parameter int ADDR_W  = 5
) (
  input  logic         clk,
  input  logic         rst,
  wb_regfile_if.slave  bus
);
  logic [ADDR_W-1:0] s1_wd_q, s2_wd_q;
  logic              s1_wreg_q, s2_wreg_q;
  logic [REG_W-1:0]  s1_wdata_q, s2_wdata_q;
  logic [REG_W-1:0]  regs_q [REG_NUM];
  logic              commit;
  assign commit         = s2_wreg_q && s2_wd_q != '0 && !bus.stall_i && !bus.flush_i;
  assign bus.wb_we_o    = commit;
  assign bus.wb_waddr_o = s2_wd_q;
  assign bus.wb_wdata_o = s2_wdata_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst || bus.flush_i) begin
      s1_wd_q    <= '0;
      s1_wreg_q  <= 1'b0;
      s1_wdata_q <= '0;
      s2_wd_q    <= '0;
      s2_wreg_q  <= 1'b0;
      s2_wdata_q <= '0;
    end else if (!bus.stall_i) begin
      s1_wd_q    <= bus.ex_wd_i;
      s1_wreg_q  <= bus.ex_wreg_i;
      s1_wdata_q <= bus.ex_wdata_i;
      s2_wd_q    <= s1_wd_q;
      s2_wreg_q  <= s1_wreg_q;
      s2_wdata_q <= s1_wdata_q;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < REG_NUM; i++) regs_q[i] <= '0;
    end else if (commit) begin
      regs_q[s2_wd_q] <= s2_wdata_q;
    end
  end
  // Youngest in-flight copy wins: execute, then s1, then s2, then the array.
  function automatic logic [REG_W-1:0] rd(input logic re, input logic [ADDR_W-1:0] a);
    return (rst || !re || a == '0)            ? '0 :
           (bus.ex_wreg_i && bus.ex_wd_i == a) ? bus.ex_wdata_i :
           (s1_wreg_q && s1_wd_q == a)         ? s1_wdata_q :
           (s2_wreg_q && s2_wd_q == a)         ? s2_wdata_q :
                                                 regs_q[a];
  endfunction
  always_comb begin
    bus.rdata1_o = rd(bus.re1_i, bus.raddr1_i);
    bus.rdata2_o = rd(bus.re2_i, bus.raddr2_i);
  end
endmodule

// File: tb/tb_wb_regfile.sv
// tb_wb_regfile: scoreboard bench; reference model is an array plus two in-flight result slots.
module tb_wb_regfile;
  logic clk = 1'b1;
  logic rst = 1'b0;
  wb_regfile_if bus();
  wb_regfile dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;

  typedef struct packed {logic [4:0] wd; logic w; logic [31:0] d;} res_t;
  typedef struct packed {logic [31:0] r1; logic [31:0] r2; logic we; logic [4:0] wa; logic [31:0] wdat;} exp_t;
  exp_t        sb [$];
  logic [31:0] mem [32];
  res_t        s1, s2;
  int          vec = 0, bad = 0;

  function automatic logic [31:0] ref_rd(input logic r, input logic re, input logic [4:0] a, input res_t ex);
    if (r || !re || a == 0) return 32'h0;
    if (ex.w && ex.wd == a) return ex.d;
    if (s1.w && s1.wd == a) return s1.d;
    if (s2.w && s2.wd == a) return s2.d;
    return mem[a];
  endfunction

  task automatic cmp(input string n, input logic [31:0] act, input logic [31:0] req);
    vec++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", n, act, req, $time);
    end
  endtask

  always @(negedge clk) begin : mon
    exp_t e;
    if (sb.size() != 0) begin
      e = sb.pop_front();
      cmp("rdata1", bus.rdata1_o, e.r1);
      cmp("rdata2", bus.rdata2_o, e.r2);
      cmp("wb_we", {31'b0, bus.wb_we_o}, {31'b0, e.we});
      if (e.we) begin
        cmp("wb_waddr", {27'b0, bus.wb_waddr_o}, {27'b0, e.wa});
        cmp("wb_wdata", bus.wb_wdata_o, e.wdat);
      end
    end
  end

  task automatic cyc(input logic r, input logic [4:0] wd, input logic w, input logic [31:0] d,
                     input logic st, input logic fl, input logic re1, input logic [4:0] a1,
                     input logic re2, input logic [4:0] a2);
    res_t ex;
    exp_t e;
    logic com;
    rst = r; bus.ex_wd_i = wd; bus.ex_wreg_i = w; bus.ex_wdata_i = d;
    bus.stall_i = st; bus.flush_i = fl;
    bus.re1_i = re1; bus.raddr1_i = a1; bus.re2_i = re2; bus.raddr2_i = a2;
    ex = '{wd: wd, w: w, d: d};
    com = !r && s2.w && s2.wd != 0 && !st && !fl;
    e.r1 = ref_rd(r, re1, a1, ex);
    e.r2 = ref_rd(r, re2, a2, ex);
    e.we = com; e.wa = s2.wd; e.wdat = s2.d;
    sb.push_back(e);
    @(posedge clk);
    if (r) begin
      foreach (mem[i]) mem[i] = 32'h0;
      s1 = '0; s2 = '0;
    end else begin
      if (com) mem[s2.wd] = s2.d;
      if (fl) begin s1 = '0; s2 = '0; end
      else if (!st) begin s2 = s1; s1 = ex; end
    end
    #1;
  endtask

  task automatic wr(input logic [4:0] wd, input logic [31:0] d, input logic [4:0] a);
    cyc(0, wd, 1, d, 0, 0, 1, a, 1, a);
  endtask

  task automatic idle(input logic [4:0] a, input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 32'h0, 0, 0, 1, a, 1, 0);
  endtask

  initial begin
    foreach (mem[i]) mem[i] = 32'h0;
    s1 = '0; s2 = '0;
    #1;
    cyc(1, 0, 0, 0, 0, 0, 1, 5, 1, 5);
    for (int a = 0; a < 32; a++) cyc(0, 0, 0, 0, 0, 0, 1, 5'(a), 1, 5'(31 - a));
    cyc(0, 0, 1, 32'hFFFF_FFFF, 0, 0, 1, 0, 1, 0);
    idle(0, 3);
    wr(3, 32'h1111_1111, 3);
    idle(3, 4);
    wr(7, 32'hA, 7); wr(7, 32'hB, 7); wr(7, 32'hC, 7);
    idle(7, 4);
    wr(9, 32'h55, 9);
    idle(9, 1);
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 1, 0, 1, 9, 1, 9);
    idle(9, 2);
    wr(4, 32'h1, 4);
    idle(4, 3);
    wr(4, 32'h2, 4); wr(4, 32'h3, 4);
    cyc(0, 0, 0, 0, 1, 1, 1, 4, 1, 4);
    idle(4, 3);
    wr(12, 32'h99, 12);
    cyc(1, 0, 0, 0, 0, 0, 1, 12, 1, 12);
    idle(12, 3);
    for (int i = 0; i < 1500; i++) begin
      logic big;
      big = ($urandom_range(7) == 0);
      cyc($urandom_range(99) == 0,
          5'(big ? $urandom_range(31) : $urandom_range(7)), 1'($urandom_range(1)), $urandom,
          $urandom_range(4) == 0, $urandom_range(19) == 0,
          $urandom_range(9) != 0, 5'(big ? $urandom_range(31) : $urandom_range(7)),
          $urandom_range(9) != 0, 5'($urandom_range(7)));
    end
    idle(0, 3);
    @(negedge clk); #1;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL scoreboard: %0d entries pending, expected 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
    $finish;
  end
endmodule
